// File: rtl/instr_loader.sv
// instr_loader: streams 9-bit words into instruction memory, zero-fills the rest,
// then releases the CPU and reports word count and XOR checksum.
module instr_loader #(
    parameter int SIZE = 1024,
    parameter int AW   = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          word_valid,
    input  logic [8:0]    word_data,
    input  logic          word_last,
    output logic          word_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [8:0]    wr_data,
    output logic          cpu_hold,
    output logic          done,
    output logic          error,
    output logic [AW:0]   count,
    output logic [8:0]    checksum
);
    typedef enum logic [2:0] {IDLE, LOAD, CLEAR, FLUSH, DONE, ERR} state_t;
    localparam logic [AW-1:0] LAST = AW'(SIZE - 1);
    state_t        state, state_n;
    logic [AW-1:0] ptr, ptr_n, waddr_n;
    logic [AW:0]   cnt_n;
    logic [8:0]    sum_n, wdata_n;
    logic          wen_n, hs, at_end;
    assign word_ready = state == LOAD;
    assign done       = state == DONE;
    assign error      = state == ERR;
    assign cpu_hold   = state != DONE;
    assign hs         = word_valid & word_ready;
    assign at_end     = ptr == LAST;
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cnt_n   = count;
        sum_n   = checksum;
        wen_n   = 1'b0;
        waddr_n = wr_addr;
        wdata_n = wr_data;
        case (state)
            LOAD: if (hs) begin
                wen_n   = 1'b1;
                waddr_n = ptr;
                wdata_n = word_data;
                ptr_n   = ptr + 1'b1;
                cnt_n   = count + 1'b1;
                sum_n   = checksum ^ word_data;
                state_n = at_end ? (word_last ? FLUSH : ERR) : (word_last ? CLEAR : LOAD);
            end
            CLEAR: begin
                wen_n   = 1'b1;
                waddr_n = ptr;
                wdata_n = '0;
                ptr_n   = ptr + 1'b1;
                state_n = at_end ? FLUSH : CLEAR;
            end
            FLUSH: state_n = DONE;
            // IDLE, DONE and ERR all wait for a (re)start
            default: if (start) begin
                state_n = LOAD;
                ptr_n   = '0;
                cnt_n   = '0;
                sum_n   = '0;
            end
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            count    <= '0;
            checksum <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            count    <= cnt_n;
            checksum <= sum_n;
            wr_en    <= wen_n;
            wr_addr  <= waddr_n;
            wr_data  <= wdata_n;
        end
    end
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: directed, self-checking bench for instr_loader with SIZE=8.
module tb_instr_loader;
    logic       clk = 0, reset = 1, start = 0, word_valid = 0, word_last = 0;
    logic [8:0] word_data = '0;
    logic       word_ready, wr_en, cpu_hold, done, error;
    logic [2:0] wr_addr;
    logic [8:0] wr_data, checksum;
    logic [3:0] count;
    int checks = 0, failures = 0;

    instr_loader #(.SIZE(8), .AW(3)) dut (
        .clk(clk), .reset(reset), .start(start), .word_valid(word_valid),
        .word_data(word_data), .word_last(word_last), .word_ready(word_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .cpu_hold(cpu_hold),
        .done(done), .error(error), .count(count), .checksum(checksum)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input string name);
        start = 1;
        tick;
        start = 0;
        checks++;
        if ({word_ready, cpu_hold, done, error, count, checksum} !== {4'b1100, 4'd0, 9'd0}) begin
            failures++;
            $display("FAIL %s_start: ready=%b hold=%b done=%b err=%b count=%0d sum=%h want 1 1 0 0 0 000",
                     name, word_ready, cpu_hold, done, error, count, checksum);
        end
    endtask

    task automatic send(input string name, input logic [8:0] d, input logic last, input logic [2:0] a);
        word_valid = 1;
        word_data  = d;
        word_last  = last;
        tick;
        word_valid = 0;
        checks++;
        if ({wr_en, wr_addr, wr_data} !== {1'b1, a, d}) begin
            failures++;
            $display("FAIL %s_write: en=%b addr=%0d data=%h want 1 %0d %h", name, wr_en, wr_addr, wr_data, a, d);
        end
    endtask

    task automatic wait_done(input string name, input logic [3:0] c, input logic [8:0] s);
        int n = 0;
        while (!done && n < 40) begin
            tick;
            n++;
        end
        checks++;
        if ({done, cpu_hold, count, checksum} !== {2'b10, c, s}) begin
            failures++;
            $display("FAIL %s_done: done=%b hold=%b count=%0d sum=%h want 1 0 %0d %h",
                     name, done, cpu_hold, count, checksum, c, s);
        end
    endtask

    task automatic test_reset;
        reset = 1;
        tick;
        tick;
        checks++;
        if ({word_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error, count, checksum} !== {2'b00, 3'd0, 9'd0, 3'b100, 4'd0, 9'd0}) begin
            failures++;
            $display("FAIL reset_values: ready=%b en=%b addr=%0d data=%h hold=%b done=%b err=%b count=%0d sum=%h",
                     word_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error, count, checksum);
        end
        reset = 0;
        tick;
        checks++;
        if ({word_ready, cpu_hold, done} !== 3'b010) begin
            failures++;
            $display("FAIL idle_hold: ready=%b hold=%b done=%b want 0 1 0", word_ready, cpu_hold, done);
        end
    endtask

    task automatic test_basic;
        start_load("basic");
        send("basic_w0", 9'h1AB, 0, 0);
        send("basic_w1", 9'h0F0, 0, 1);
        send("basic_w2", 9'h155, 1, 2);
        for (int j = 2; j <= 6; j++) begin
            tick;
            checks++;
            if ({wr_en, wr_addr, wr_data, done, cpu_hold} !== {1'b1, 3'(j + 1), 9'd0, 2'b01}) begin
                failures++;
                $display("FAIL basic_fill t+%0d: en=%b addr=%0d data=%h done=%b hold=%b want 1 %0d 000 0 1",
                         j, wr_en, wr_addr, wr_data, done, cpu_hold, j + 1);
            end
        end
        tick;
        checks++;
        if ({done, cpu_hold, wr_en, word_ready, count, checksum} !== {4'b1000, 4'd3, 9'h00E}) begin
            failures++;
            $display("FAIL basic_done: done=%b hold=%b en=%b ready=%b count=%0d sum=%h want 1 0 0 0 3 00e",
                     done, cpu_hold, wr_en, word_ready, count, checksum);
        end
    endtask

    task automatic test_full;
        start_load("full");
        for (int i = 0; i < 8; i++) send("full_w", 9'(i + 1), i == 7, 3'(i));
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL full_flush: done=%b want 0", done);
        end
        tick;
        checks++;
        if ({done, cpu_hold, wr_en, count, checksum} !== {3'b100, 4'd8, 9'h008}) begin
            failures++;
            $display("FAIL full_done: done=%b hold=%b en=%b count=%0d sum=%h want 1 0 0 8 008",
                     done, cpu_hold, wr_en, count, checksum);
        end
    endtask

    task automatic test_overflow;
        start_load("ovf");
        for (int i = 0; i < 8; i++) send("ovf_w", 9'h100 + 9'(i), 0, 3'(i));
        checks++;
        if ({error, cpu_hold, word_ready, done, count} !== {4'b1100, 4'd8}) begin
            failures++;
            $display("FAIL ovf_err: err=%b hold=%b ready=%b done=%b count=%0d want 1 1 0 0 8",
                     error, cpu_hold, word_ready, done, count);
        end
        tick;
        checks++;
        if ({wr_en, error} !== 2'b01) begin
            failures++;
            $display("FAIL ovf_nofill: en=%b err=%b want 0 1", wr_en, error);
        end
        start_load("ovf_restart");
        send("ovf_r0", 9'h055, 1, 0);
        wait_done("ovf_restart", 4'd1, 9'h055);
    endtask

    task automatic test_gapped;
        logic [8:0] d [3] = '{9'h0A5, 9'h13C, 9'h011};
        start_load("gap");
        for (int i = 0; i < 3; i++) begin
            send("gap_w", d[i], i == 2, 3'(i));
            word_data = ~d[i];
            word_last = 1;
            tick;
            if (i < 2) begin
                checks++;
                if ({wr_en, word_ready} !== 2'b01) begin
                    failures++;
                    $display("FAIL gap_idle%0d: en=%b ready=%b want 0 1", i, wr_en, word_ready);
                end
            end
        end
        wait_done("gap", 4'd3, 9'h0A5 ^ 9'h13C ^ 9'h011);
    endtask

    task automatic test_reset_mid;
        start_load("rmid");
        send("rmid_w0", 9'h0C3, 0, 0);
        send("rmid_w1", 9'h03C, 0, 1);
        #2 reset = 1;
        #1;
        checks++;
        if ({word_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error, count, checksum} !== {2'b00, 3'd0, 9'd0, 3'b100, 4'd0, 9'd0}) begin
            failures++;
            $display("FAIL rmid_async: ready=%b en=%b addr=%0d data=%h hold=%b count=%0d sum=%h",
                     word_ready, wr_en, wr_addr, wr_data, cpu_hold, count, checksum);
        end
        tick;
        reset = 0;
        start_load("rmid_restart");
        send("rmid_r0", 9'h1FF, 1, 0);
        for (int j = 2; j <= 8; j++) begin
            tick;
            checks++;
            if ({wr_en, wr_addr, wr_data} !== {1'b1, 3'(j - 1), 9'd0}) begin
                failures++;
                $display("FAIL rmid_fill t+%0d: en=%b addr=%0d data=%h want 1 %0d 000", j, wr_en, wr_addr, wr_data, j - 1);
            end
        end
        tick;
        checks++;
        if ({done, count, checksum} !== {1'b1, 4'd1, 9'h1FF}) begin
            failures++;
            $display("FAIL rmid_done: done=%b count=%0d sum=%h want 1 1 1ff", done, count, checksum);
        end
    endtask

    task automatic test_start_ignored;
        start_load("sig");
        start = 1;
        send("sig_w0", 9'h011, 0, 0);
        send("sig_w1", 9'h022, 1, 1);
        tick;
        start = 0;
        checks++;
        if ({wr_en, wr_addr, wr_data, word_ready, count} !== {1'b1, 3'd2, 9'd0, 1'b0, 4'd2}) begin
            failures++;
            $display("FAIL sig_clear: en=%b addr=%0d data=%h ready=%b count=%0d want 1 2 000 0 2",
                     wr_en, wr_addr, wr_data, word_ready, count);
        end
        wait_done("sig", 4'd2, 9'h033);
        start_load("sig_done_restart");
        send("sig_r0", 9'h0AA, 1, 0);
        wait_done("sig_restart", 4'd1, 9'h0AA);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_full;
        test_overflow;
        test_gapped;
        test_reset_mid;
        test_start_ignored;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
